// File: rtl/lif_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lif_pkg : shared types and constants for the LIF neuron and its loader
// Rev 1.0
// ---------------------------------------------------------------------------
package lif_pkg;

  localparam int WEIGHT_W = 3;
  localparam int LEAK_W   = 2;
  localparam int THRESH_W = 8;

  localparam logic [7:0] CHK_KEY = 8'h5A;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CHKSUM  = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_B0     = 3'd0,
    S_B1     = 3'd1,
    S_B2     = 3'd2,
    S_CHK    = 3'd3,
    S_COMMIT = 3'd4
  } state_e;

  function automatic logic [7:0] frame_checksum(input logic [7:0] b0,
                                                input logic [7:0] b1,
                                                input logic [7:0] b2);
    return b0 ^ b1 ^ b2 ^ CHK_KEY;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lif_cfg_timeout.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lif_cfg_timeout : idle-cycle counter, expires on the TIMEOUT-th idle cycle
// Rev 1.0
// ---------------------------------------------------------------------------
module lif_cfg_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !run) cnt_d = '0;
    else               cnt_d = cnt_q + 8'd1;
  end

  // Fires on the edge where the idle count would reach TIMEOUT; an accepted
  // byte in that same cycle suppresses it.
  assign expired = run && !clear && (cnt_q == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/lif_param_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lif_param_loader : byte-serial checked loader for lif_neuron parameters
// Rev 1.0
// ---------------------------------------------------------------------------
module lif_param_loader
  import lif_pkg::*;
#(
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  input  logic [7:0]          cfg_data,
  output logic                cfg_ready,
  output logic [WEIGHT_W-1:0] weight_a,
  output logic [WEIGHT_W-1:0] weight_b,
  output logic [LEAK_W-1:0]   leak_config,
  output logic [THRESH_W-1:0] threshold_min,
  output logic [THRESH_W-1:0] threshold_max,
  output logic                params_ready,
  output logic                nrn_reset,
  output logic [1:0]          err_code,
  output logic [7:0]          commit_count
);

  localparam logic [3:0] RST_LAST = 4'(RST_CYCLES);

  state_e              state_q, state_d;
  logic [7:0]          b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic [WEIGHT_W-1:0] weight_a_q, weight_a_d, weight_b_q, weight_b_d;
  logic [LEAK_W-1:0]   leak_q, leak_d;
  logic [THRESH_W-1:0] tmin_q, tmin_d, tmax_q, tmax_d;
  logic                params_ready_q, params_ready_d;
  logic                nrn_reset_q, nrn_reset_d;
  logic [1:0]          err_q, err_d;
  logic [7:0]          count_q, count_d;
  logic [3:0]          rst_cnt_q, rst_cnt_d;
  logic                accept;
  logic                idle_run;
  logic                expired;

  assign cfg_ready = !reset && (state_q != S_COMMIT);
  assign accept    = cfg_valid && cfg_ready;
  assign idle_run  = (state_q == S_B1) || (state_q == S_B2) || (state_q == S_CHK);

  lif_cfg_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .run     (idle_run),
    .clear   (accept),
    .expired (expired)
  );

  always_comb begin
    state_d        = state_q;
    b0_d           = b0_q;
    b1_d           = b1_q;
    b2_d           = b2_q;
    weight_a_d     = weight_a_q;
    weight_b_d     = weight_b_q;
    leak_d         = leak_q;
    tmin_d         = tmin_q;
    tmax_d         = tmax_q;
    params_ready_d = params_ready_q;
    nrn_reset_d    = nrn_reset_q;
    err_d          = err_q;
    count_d        = count_q;
    rst_cnt_d      = '0;

    case (state_q)
      S_B0: if (accept) begin
        b0_d    = cfg_data;
        err_d   = ERR_NONE;
        state_d = S_B1;
      end
      S_B1: if (accept) begin
        b1_d    = cfg_data;
        state_d = S_B2;
      end
      S_B2: if (accept) begin
        b2_d    = cfg_data;
        state_d = S_CHK;
      end
      S_CHK: if (accept) begin
        if (cfg_data != frame_checksum(b0_q, b1_q, b2_q)) begin
          err_d   = ERR_CHKSUM;
          state_d = S_B0;
        end else if (b1_q > b2_q) begin
          err_d   = ERR_RANGE;
          state_d = S_B0;
        end else begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        // First cycle publishes the shadow set; the pulse then runs RST_CYCLES.
        rst_cnt_d = rst_cnt_q + 4'd1;
        if (rst_cnt_q == 4'd0) begin
          weight_a_d     = b0_q[7:5];
          weight_b_d     = b0_q[4:2];
          leak_d         = b0_q[1:0];
          tmin_d         = b1_q;
          tmax_d         = b2_q;
          count_d        = count_q + 8'd1;
          params_ready_d = 1'b0;
          nrn_reset_d    = 1'b1;
        end
        if (rst_cnt_q == RST_LAST) begin
          rst_cnt_d      = '0;
          params_ready_d = 1'b1;
          nrn_reset_d    = 1'b0;
          state_d        = S_B0;
        end
      end
      default: state_d = S_B0;
    endcase

    if (expired) begin
      err_d   = ERR_TIMEOUT;
      b0_d    = '0;
      b1_d    = '0;
      b2_d    = '0;
      state_d = S_B0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_B0;
      b0_q           <= '0;
      b1_q           <= '0;
      b2_q           <= '0;
      weight_a_q     <= '0;
      weight_b_q     <= '0;
      leak_q         <= '0;
      tmin_q         <= '0;
      tmax_q         <= '0;
      params_ready_q <= 1'b0;
      nrn_reset_q    <= 1'b1;
      err_q          <= ERR_NONE;
      count_q        <= '0;
      rst_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      b0_q           <= b0_d;
      b1_q           <= b1_d;
      b2_q           <= b2_d;
      weight_a_q     <= weight_a_d;
      weight_b_q     <= weight_b_d;
      leak_q         <= leak_d;
      tmin_q         <= tmin_d;
      tmax_q         <= tmax_d;
      params_ready_q <= params_ready_d;
      nrn_reset_q    <= nrn_reset_d;
      err_q          <= err_d;
      count_q        <= count_d;
      rst_cnt_q      <= rst_cnt_d;
    end
  end

  assign weight_a      = weight_a_q;
  assign weight_b      = weight_b_q;
  assign leak_config   = leak_q;
  assign threshold_min = tmin_q;
  assign threshold_max = tmax_q;
  assign params_ready  = params_ready_q;
  assign nrn_reset     = nrn_reset_q;
  assign err_code      = err_q;
  assign commit_count  = count_q;

endmodule
`default_nettype wire

// File: doc/lif_param_loader.md
# lif_param_loader

Byte-serial configuration loader that feeds parameters to `lif_neuron`. It receives a 4-byte frame over a valid/ready stream, checks the checksum and the threshold range, and commits the new parameters atomically. It then issues a reset pulse to the neuron so its adaptive threshold reloads from the new `threshold_min`. It sits between the host configuration interface and the neuron's weight, leak, threshold and `params_ready` inputs.

## Interface
Parameters:
- `RST_CYCLES`, 2: length of the neuron reset pulse after commit, 1–15.
- `TIMEOUT`, 255: maximum idle cycles between bytes inside a frame, 1–255.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cfg_valid`  in  1  byte on `cfg_data` is valid.
- `cfg_data`  in  8  configuration byte.
- `cfg_ready`  out  1  loader accepts a byte this cycle.
- `weight_a`, `weight_b`  out  3 each  committed synaptic weights.
- `leak_config`  out  2  committed leak select.
- `threshold_min`, `threshold_max`  out  8 each  committed threshold bounds.
- `params_ready`  out  1  committed parameters are valid and the neuron may run.
- `nrn_reset`  out  1  synchronous reset to the neuron after commit.
- `err_code`  out  2  last frame error: 00 none, 01 checksum, 10 range, 11 timeout.
- `commit_count`  out  8  number of successful commits, wraps at 255→0.

## Operation
- A byte is accepted on a rising edge where `cfg_valid && cfg_ready`.
- Frame layout:
  - B0 = `{weight_a[2:0], weight_b[2:0], leak_config[1:0]}`
  - B1 = `threshold_min`
  - B2 = `threshold_max`
  - B3 = `B0^B1^B2^8'h5A`
- Bytes B0–B2 go into shadow registers. Committed outputs never change mid-frame.
- FSM states: `S_B0 → S_B1 → S_B2 → S_CHK → S_COMMIT → S_B0`. Each forward transition happens on byte acceptance, except `S_COMMIT`.
- In `S_CHK`, on acceptance:
  - Checksum mismatch: `err_code`=01, go to `S_B0`.
  - Checksum good but `B1 > B2`: `err_code`=10, go to `S_B0`.
  - Checksum wins if both checks fail.
  - Otherwise go to `S_COMMIT`.
- `S_COMMIT`:
  - On entry, copy shadow registers to outputs and increment `commit_count`.
  - Hold `params_ready`=0 and `nrn_reset`=1 for exactly `RST_CYCLES` cycles.
  - Then go to `S_B0` with `params_ready`=1.
- `err_code` is sticky. It clears to 00 on acceptance of the next B0.
- Timeout:
  - An idle counter runs in `S_B1`, `S_B2` and `S_CHK`. It clears on every accepted byte.
  - When the counter reaches `TIMEOUT`: `err_code`=11, shadow data is discarded, go to `S_B0`.
  - If a byte is accepted in the same cycle the counter reaches `TIMEOUT`, the byte wins and no timeout occurs.
  - No timeout in `S_B0`.
- A failed frame (error or timeout) leaves the committed outputs, `params_ready` and `commit_count` unchanged.
- `equal B1 == B2` is legal.

## Timing
- Reset values:
  - `cfg_ready`=0 while `reset` is asserted, 1 in `S_B0` on the first cycle after release.
  - All parameter outputs 0.
  - `params_ready`=0, `nrn_reset`=1 (the neuron is held in reset until the first commit completes).
  - `err_code`=00, `commit_count`=0, FSM in `S_B0`.
- `cfg_ready`=1 in `S_B0`–`S_CHK`, 0 in `S_COMMIT`.
- Latency from B3 acceptance (edge N):
  - New outputs and `nrn_reset`=1 from edge N+1.
  - `nrn_reset` falls and `params_ready` rises at edge N+1+`RST_CYCLES`.
  - The next B0 can be accepted at that same edge.
- Reset asserted mid-frame or mid-commit returns everything to the reset values immediately. No partial commit.
- `commit_count` increments at edge N+1.

## Structure
- Shared package `lif_pkg`:
  - FSM state enum.
  - `err_code` localparams.
  - Checksum key `8'h5A`.
  - Widths of weight, leak and threshold fields, shared with `lif_neuron`.
- One natural sub-module: `lif_cfg_timeout`, the idle counter with clear and expiry, parameterised by `TIMEOUT`.
- Everything else stays flat.

## Test plan
- Frame `8'hDB, 8'h10, 8'h40, 8'hD1` with `cfg_valid` held high:
  - Accepted in 4 cycles.
  - `weight_a`=6, `weight_b`=6, `leak_config`=3, thresholds 16/64.
  - `nrn_reset` high 2 cycles, then `params_ready`=1, `commit_count`=1.
- Same frame with B3=`8'h00`:
  - `err_code`=01, outputs unchanged.
  - A following good frame clears `err_code` when its B0 is accepted.
- Frame `8'h01, 8'h50, 8'h20, 8'h2B` (min>max, checksum good):
  - `err_code`=10, `params_ready` keeps its prior value.
- After B1, hold `cfg_valid` low for 255 cycles:
  - `err_code`=11 and `S_B0`.
  - Repeat with a byte arriving on cycle 255: no timeout.
- Assert `reset` during `S_COMMIT`:
  - All outputs return to reset values.
  - `commit_count`=0.
  - A following good frame commits normally.
- 256 good frames: `commit_count` wraps to 0 and `params_ready` stays 1 outside the commit windows.
